// File: rtl/seq_alu_pipe_if.sv
// rtl/seq_alu_pipe_if.sv - operand/result handshake bundle for seq_alu_pipe
//
// Ports (signals):
//   in_valid/in_ready   operand-side handshake
//   a, b, s             operands and 5-bit opcode
//   out_valid/out_ready result-side handshake
//   out, zero, err      result and flags
// Modports: master (issue/writeback side), slave (ALU side).
interface seq_alu_pipe_if #(
  parameter int WIDTH = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, out, zero, err
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, out, zero, err
  );
endinterface

// File: rtl/seq_alu_pipe.sv
// rtl/seq_alu_pipe.sv - clocked ALU with iterative multiply/divide and valid/ready handshakes
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_pipe_if.slave: in_valid/in_ready, a, b, s, out_valid/out_ready, out, zero, err
// Parameters: WIDTH (operand width, >= 8), SHW (shift-amount width, 2**SHW >= WIDTH).
// bus must be instantiated with the same WIDTH.
// Optional macro ALU_REM_EN: enables opcode 01101 (REM) on the iterative divider.
module seq_alu_pipe #(
  parameter int WIDTH = 40,
  parameter int SHW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_alu_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [SHW:0]     WIDTH_C = (SHW + 1)'(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_ADDNZ = 5'b00111;
  localparam logic [4:0] OP_MUL   = 5'b01000;
  localparam logic [4:0] OP_DIV   = 5'b01011;
  localparam logic [4:0] OP_SLL   = 5'b01100;
`ifdef ALU_REM_EN
  localparam logic [4:0] OP_REM   = 5'b01101;
`endif
  localparam logic [4:0] OP_SRL   = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_MUL,
    K_DIV,
    K_REM
  } kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // x: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV/REM)
  // y: multiplier (MUL) or divisor (DIV/REM)
  // acc: partial product (MUL) or partial remainder (DIV/REM)
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  // Single-cycle decode of the operands currently presented on the bus.
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;
  logic             go_iter;
  kind_t            iter_kind;
  logic             shamt_big;

  // One restoring-division step.
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  logic [WIDTH-1:0] fin_res;
  logic             fin_err;
  logic             div0;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

  always_comb begin
    sc_res    = '0;
    sc_err    = 1'b0;
    go_iter   = 1'b0;
    iter_kind = K_MUL;
    // Amounts at or beyond WIDTH shift everything out.
    shamt_big = ({1'b0, bus.b[SHW-1:0]} >= WIDTH_C);
    case (bus.s)
      OP_ADD:   sc_res = bus.a + bus.b;
      OP_SUB:   sc_res = bus.a - bus.b;
      OP_ADDNZ: sc_res = (bus.b != '0) ? (bus.a + bus.b) : (bus.a - bus.b);
      OP_SRL:   sc_res = shamt_big ? '0 : (bus.a >> bus.b[SHW-1:0]);
      OP_SLL:   sc_res = shamt_big ? '0 : (bus.a << bus.b[SHW-1:0]);
      OP_MUL: begin
        go_iter   = 1'b1;
        iter_kind = K_MUL;
      end
      OP_DIV: begin
        go_iter   = 1'b1;
        iter_kind = K_DIV;
      end
`ifdef ALU_REM_EN
      OP_REM: begin
        go_iter   = 1'b1;
        iter_kind = K_REM;
      end
`endif
      default: begin
        sc_res = '0;
        sc_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    rem_sh  = {acc_q, x_q[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, y_q});
    // When div_ge holds the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    div_sub = rem_sh[WIDTH-1:0] - y_q;
  end

  always_comb begin
    div0    = (y_q == '0);
    fin_res = acc_q;
    fin_err = 1'b0;
    case (kind_q)
      K_DIV: begin
        fin_res = div0 ? '1 : x_q;
        fin_err = div0;
      end
      // With a zero divisor every step keeps the shifted value, so the
      // remainder register ends up holding the original dividend.
      K_REM: begin
        fin_res = acc_q;
        fin_err = div0;
      end
      default: begin
        fin_res = acc_q;
        fin_err = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    out_d   = out_q;
    zero_d  = zero_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (go_iter) begin
            kind_d  = iter_kind;
            x_d     = bus.a;
            y_d     = bus.b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            out_d   = sc_res;
            zero_d  = (sc_res == '0);
            err_d   = sc_err;
            state_d = S_DONE;
          end
        end
      end

      S_BUSY: begin
        // WIDTH iteration edges, then one edge to publish the result.
        if (cnt_q == CNT_MAX) begin
          out_d   = fin_res;
          zero_d  = (fin_res == '0);
          err_d   = fin_err;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (kind_q == K_MUL) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = {x_q[WIDTH-2:0], 1'b0};
            y_d   = {1'b0, y_q[WIDTH-1:1]};
          end else begin
            acc_d = div_ge ? div_sub : rem_sh[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], div_ge};
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_MUL;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_alu_pipe.sv
// tb/tb_seq_alu_pipe.sv - directed self-checking bench for seq_alu_pipe
module tb_seq_alu_pipe;

  localparam int W = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_alu_pipe_if #(.WIDTH(W)) bus ();

  seq_alu_pipe #(.WIDTH(W), .SHW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one operation; returns #1 after the accepting edge.
  task automatic issue(input string tag, input logic [4:0] op,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    chk_b({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.a        = av;
    bus.b        = bv;
    bus.s        = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid (0 = visible right after accept).
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_b({tag, "_valid_after"}, bus.out_valid, 1'b0);
    chk_b({tag, "_ready_after"}, bus.in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_out, input logic exp_zero,
                        input logic exp_err, input int exp_lat);
    int lat;
    issue(tag, op, av, bv);
    wait_out(lat);
    chk_i({tag, "_lat"}, lat, exp_lat);
    chk_d({tag, "_out"}, bus.out, exp_out);
    chk_b({tag, "_zero"}, bus.zero, exp_zero);
    chk_b({tag, "_err"}, bus.err, exp_err);
    take_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_ready;
    logic [W-1:0] held_out;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.s         = '0;

    // Reset state
    #1;
    chk_d("rst_out", bus.out, 40'h0);
    chk_b("rst_valid", bus.out_valid, 1'b0);
    chk_b("rst_zero", bus.zero, 1'b0);
    chk_b("rst_err", bus.err, 1'b0);
    chk_b("rst_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle arithmetic
    run_op("add", 5'b00101, 40'd5, 40'd7, 40'd12, 1'b0, 1'b0, 0);
    run_op("sub", 5'b00110, 40'd3, 40'd5, 40'hFF_FFFF_FFFE, 1'b0, 1'b0, 0);
    run_op("addnz0", 5'b00111, 40'd9, 40'd0, 40'd9, 1'b0, 1'b0, 0);
    run_op("addnz3", 5'b00111, 40'd9, 40'd3, 40'd12, 1'b0, 1'b0, 0);

    // Multiply: latency, in_ready low, operand changes and in_valid during BUSY ignored
    issue("mul", 5'b01000, 40'd1000, 40'd3000);
    lat = 0;
    busy_ready = 0;
    bus.in_valid = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.in_ready !== 1'b0) busy_ready++;
      bus.a = ~bus.a;
      bus.b = bus.b + 40'd1;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk_i("mul_lat", lat, 41);
    chk_i("mul_busy_in_ready", busy_ready, 0);
    chk_d("mul_out", bus.out, 40'd3000000);
    chk_b("mul_err", bus.err, 1'b0);
    take_out("mul");
    run_op("mul_wrap", 5'b01000, 40'h80_0000_0001, 40'd3, 40'h80_0000_0003, 1'b0, 1'b0, 41);

    // Divide
    run_op("div", 5'b01011, 40'd100, 40'd7, 40'd14, 1'b0, 1'b0, 41);
    run_op("div0", 5'b01011, 40'd9, 40'd0, 40'hFF_FFFF_FFFF, 1'b0, 1'b1, 41);
`ifdef ALU_REM_EN
    run_op("rem", 5'b01101, 40'd100, 40'd7, 40'd2, 1'b0, 1'b0, 41);
    run_op("rem0", 5'b01101, 40'd9, 40'd0, 40'd9, 1'b0, 1'b1, 41);
`else
    run_op("rem_illegal", 5'b01101, 40'd100, 40'd7, 40'd0, 1'b1, 1'b1, 0);
`endif

    // Shifts
    run_op("srl", 5'b10100, 40'hF0, 40'd4, 40'h0F, 1'b0, 1'b0, 0);
    run_op("sll39", 5'b01100, 40'd1, 40'd39, 40'h80_0000_0000, 1'b0, 1'b0, 0);
    run_op("sll40", 5'b01100, 40'd1, 40'd40, 40'd0, 1'b1, 1'b0, 0);
    run_op("srl63", 5'b10100, 40'hFF_FFFF_FFFF, 40'd63, 40'd0, 1'b1, 1'b0, 0);

    // Illegal opcode
    run_op("illegal", 5'b11111, 40'd5, 40'd7, 40'd0, 1'b1, 1'b1, 0);

    // Backpressure: result held while out_ready low
    issue("bp", 5'b00101, 40'd2, 40'd3);
    wait_out(lat);
    chk_i("bp_lat", lat, 0);
    held_out = bus.out;
    chk_d("bp_out", held_out, 40'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_b("bp_hold_valid", bus.out_valid, 1'b1);
      chk_d("bp_hold_out", bus.out, 40'd5);
      chk_b("bp_hold_zero", bus.zero, 1'b0);
      chk_b("bp_hold_err", bus.err, 1'b0);
      chk_b("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    take_out("bp");

    // Reset in the middle of a divide
    issue("rstdiv", 5'b01011, 40'd100, 40'd7);
    repeat (20) @(posedge clk);
    #1;
    chk_b("rstdiv_busy", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_d("rstdiv_out", bus.out, 40'd0);
    chk_b("rstdiv_valid", bus.out_valid, 1'b0);
    chk_b("rstdiv_err", bus.err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_b("rstdiv_in_ready", bus.in_ready, 1'b1);
    chk_b("rstdiv_no_result", bus.out_valid, 1'b0);
    run_op("post_rst_add", 5'b00101, 40'd1, 40'd1, 40'd2, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
